// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - stage/index walker feeding the FFT index mapper
//
// Walks every stage of an N = 2^MSB point transform and, within each stage,
// every linear index 0..N-1, handing index/stage pairs downstream over a
// valid/ready handshake. Write-back completions are counted so a stage only
// ends once all N results of the current stage have landed in RAM.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin a transform (only honoured in IDLE)
//   busy                  high while a transform is in progress
//   done                  one-cycle pulse when the last stage has drained
//   idx_valid, idx_ready  handshake for index/stage
//   index, stage          linear index and current stage
//   last                  index = N-1 while idx_valid
//   wb_valid              one pulse per completed write-back
//   stage_done            one-cycle pulse on every stage advance / completion
//   err                   sticky: unexpected write-back seen
module fft_stage_sequencer #(
    parameter int MSB = 8,
    parameter int SW  = $clog2(MSB)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           idx_valid,
    input  logic           idx_ready,
    output logic [MSB-1:0] index,
    output logic [SW-1:0]  stage,
    output logic           last,
    input  logic           wb_valid,
    output logic           stage_done,
    output logic           err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [MSB-1:0] LAST_IDX   = {MSB{1'b1}};
    localparam logic [MSB:0]   FULL_CNT   = {1'b1, {MSB{1'b0}}};
    localparam logic [SW-1:0]  LAST_STAGE = SW'(MSB - 1);

    state_t         state_q, state_d;
    logic [MSB-1:0] index_q, index_d;
    logic [SW-1:0]  stage_q, stage_d;
    logic [MSB:0]   wb_cnt_q, wb_cnt_d;
    logic           idx_valid_q, idx_valid_d;
    logic           done_q, done_d;
    logic           stage_done_q, stage_done_d;
    logic           err_q, err_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            stage_q      <= '0;
            wb_cnt_q     <= '0;
            idx_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            stage_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            stage_q      <= stage_d;
            wb_cnt_q     <= wb_cnt_d;
            idx_valid_q  <= idx_valid_d;
            done_q       <= done_d;
            stage_done_q <= stage_done_d;
            err_q        <= err_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        stage_d      = stage_q;
        wb_cnt_d     = wb_cnt_q;
        idx_valid_d  = idx_valid_q;
        done_d       = 1'b0;
        stage_done_d = 1'b0;
        err_d        = err_q;

        // Write-backs may still trail the last handshake, so counting spans
        // both RUN and DRAIN. A write-back beyond N means the datapath and
        // the sequencer disagree; flag it and hold the count at N.
        if (state_q != ST_IDLE && wb_valid) begin
            if (wb_cnt_q == FULL_CNT) begin
                err_d = 1'b1;
            end else begin
                wb_cnt_d = wb_cnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    index_d     = '0;
                    stage_d     = '0;
                    wb_cnt_d    = '0;
                    idx_valid_d = 1'b1;
                    err_d       = 1'b0;
                end
                // Nothing is in flight in IDLE, so any write-back is stray.
                if (wb_valid) begin
                    err_d = 1'b1;
                end
            end

            ST_RUN: begin
                if (idx_valid_q && idx_ready) begin
                    if (index_q != LAST_IDX) begin
                        index_d = index_q + 1'b1;
                    end else begin
                        state_d     = ST_DRAIN;
                        idx_valid_d = 1'b0;
                    end
                end
            end

            ST_DRAIN: begin
                // The next stage reads what this stage wrote, so it may only
                // begin once every write-back has been seen.
                if (wb_cnt_q == FULL_CNT) begin
                    stage_done_d = 1'b1;
                    index_d      = '0;
                    wb_cnt_d     = '0;
                    if (stage_q != LAST_STAGE) begin
                        state_d     = ST_RUN;
                        stage_d     = stage_q + 1'b1;
                        idx_valid_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        stage_d = '0;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d     = ST_IDLE;
                idx_valid_d = 1'b0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        last = idx_valid_q && (index_q == LAST_IDX);
    end

    assign idx_valid  = idx_valid_q;
    assign index      = index_q;
    assign stage      = stage_q;
    assign done       = done_q;
    assign stage_done = stage_done_q;
    assign err        = err_q;

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Control block that sits directly upstream of the FFT index mapper. It walks each FFT stage and, within each stage, every linear index, presenting `index`/`stage` pairs over a valid/ready handshake. The index mapper consumes these pairs combinationally and turns them into permuted memory addresses. The sequencer counts write-back completions from the butterfly/RAM path and only advances to the next stage once the current stage has fully drained, which prevents read-after-write hazards between stages.

## Interface
Parameters:
- `MSB`, default 8: index width. Transform size is N = 2^MSB; number of stages is MSB.
- `SW`, default $clog2(MSB): stage field width, matching the mapper's `stage` input.

Ports:
- `clk`  in  1  single system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a transform; sampled only in IDLE
- `busy`  out  1  high in RUN and DRAIN
- `done`  out  1  one-cycle pulse when the final stage has drained
- `idx_valid`  out  1  `index`/`stage` are valid
- `idx_ready`  in  1  downstream accepts the current index
- `index`  out  MSB  linear index, 0..N-1, fed to the mapper's `index_in`
- `stage`  out  SW  current stage, 0..MSB-1, fed to the mapper's `stage`
- `last`  out  1  high with `idx_valid` when `index` = N-1
- `wb_valid`  in  1  one pulse per completed write-back of one index
- `stage_done`  out  1  one-cycle pulse on each stage advance and on completion
- `err`  out  1  sticky: a write-back pulse arrived when none was expected

## Operation
- States: IDLE, RUN, DRAIN.
- **IDLE:**
  - `start`=1 → RUN with `index`=0, `stage`=0, `wb_cnt`=0; `err` is cleared.
  - `wb_valid` in IDLE sets `err`.
- **RUN:**
  - `idx_valid`=1.
  - On `idx_valid && idx_ready`: if `index` < N-1, increment `index`; else go to DRAIN with `idx_valid`=0.
  - Without `idx_ready`, `index` and `stage` hold stable.
- **Write-back counter:**
  - `wb_cnt` is MSB+1 bits wide and counts in both RUN and DRAIN.
  - Each `wb_valid` increments it.
  - `wb_valid` while `wb_cnt` = N sets `err`; the counter saturates at N.
- **DRAIN:**
  - `idx_valid`=0; waits until registered `wb_cnt` = N.
  - If `stage` < MSB-1: next state RUN, `stage`+1, `index`=0, `wb_cnt`=0, `stage_done` pulses.
  - If `stage` = MSB-1: next state IDLE, `done` and `stage_done` both pulse, `stage` and `index` return to 0.
- `start` outside IDLE is ignored.
- `busy` is asserted in RUN and DRAIN only.
- `last` = `idx_valid` && (`index` = N-1).
- Arithmetic: `index` wraps only by explicit reset to 0, never by overflow; `stage` never exceeds MSB-1.

## Timing
- All outputs are registered except `last` and `busy`, which decode directly from registers.
- Reset values: state IDLE, `index`=0, `stage`=0, `wb_cnt`=0, `idx_valid`=0, `done`=0, `stage_done`=0, `err`=0, `busy`=0, `last`=0.
- `start` sampled at edge E → `idx_valid`=1 with `index`=0 from edge E onward.
- With `idx_ready` held high, one index is accepted per cycle: N cycles per stage issue.
- Last `wb_valid` of a stage sampled at edge T → DRAIN observes `wb_cnt`=N in cycle T..T+1 → at edge T+1, `stage_done`=1 and the next stage's `idx_valid`=1 with `index`=0.
- `wb_valid` coinciding with the final handshake of RUN is counted normally.
- Minimum stage overhead beyond issue is one cycle after the last write-back.
- `rst_n` low mid-transform: immediately, asynchronously, forces all reset values. Write-backs still arriving after reset release, with the block in IDLE, set `err`.
- `done` and `stage_done` are each high for exactly one cycle per event.

## Test plan
- **Full run, no backpressure:**
  - Stimulus: MSB=3, `start` pulse, `idx_ready`=1, `wb_valid` echoing each handshake 2 cycles later.
  - Required response: 24 handshakes, with stages 0,1,2 each issuing indices 0..7 in order; `last` exactly 3 times; `stage_done` 3 pulses; `done` 1 pulse; `busy` low afterwards; `err`=0.
- **Backpressure:**
  - Stimulus: `idx_ready` toggling 1,0,0,1 repeatedly.
  - Required response: `index`/`stage` stable while `idx_ready`=0; no index skipped or duplicated; handshake count per stage = 8.
- **Delayed drain:**
  - Stimulus: withhold the final `wb_valid` of stage 0 for 10 cycles.
  - Required response: `idx_valid`=0 and `stage`=0 throughout; stage 1 `index`=0 appears exactly 1 cycle after that `wb_valid` is sampled.
- **Error:**
  - Stimulus: `wb_valid` in IDLE, and a 9th `wb_valid` in one stage.
  - Required response: `err` set in both cases; `wb_cnt` stays 8; `err` is cleared by the next `start`.
- **Start while busy:**
  - Stimulus: `start` pulses during RUN and DRAIN.
  - Required response: no effect on `index`, `stage` or counters.
- **Reset mid-op:**
  - Stimulus: `rst_n` low during stage 1, index 5.
  - Required response: all outputs at their reset values without waiting for a clock edge; a fresh `start` then runs cleanly from stage 0.
